// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single synchronous-read memory.
// One access in flight at a time; ties are broken round-robin against the last grant.
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q;
  logic          port_q;        // 1 = data port owns the transaction
  logic          we_q;
  logic          last_grant_q;  // 1 = data port was granted last
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          i_ack_q, d_ack_q;
  logic [DW-1:0] i_rdata_q, d_rdata_q;

  logic          grant_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // Data wins unless the fetch port is also asking and data had the last grant.
  always_comb begin
    grant_d = d_req & (~i_req | ~last_grant_q);
    we_d    = grant_d & d_we;
    addr_d  = grant_d ? d_addr : i_addr;
    wdata_d = we_d ? d_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      // strobes default low so the memory bus reads as zero outside ISSUE
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            port_q       <= grant_d;
            we_q         <= we_d;
            last_grant_q <= grant_d;
            mem_en_q     <= 1'b1;
            mem_we_q     <= we_d;
            mem_addr_q   <= addr_d;
            mem_wdata_q  <= wdata_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (!we_q) begin
            if (port_q) d_rdata_q <= mem_rdata;
            else        i_rdata_q <= mem_rdata;
          end
          if (port_q) d_ack_q <= 1'b1;
          else        i_ack_q <= 1'b1;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ack, d_ack;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten words read back a fixed pattern derived from the address.
  logic [DW-1:0] mem [0:1023];
  bit            written [0:1023];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 10'h004) ? 32'h0050_0093 : {16'hA5A5, 6'b0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"},    32'(mem_en),    32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    check({tag, "_i_ack"},     32'(i_ack),     32'd0);
    check({tag, "_d_ack"},     32'(d_ack),     32'd0);
    check({tag, "_i_rdata"},   i_rdata,        32'd0);
    check({tag, "_d_rdata"},   d_rdata,        32'd0);
  endtask

  initial begin
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick; tick;
    check_all_zero("reset");

    // Requests during reset are overridden
    i_req = 1; i_addr = 10'h004; d_req = 1; d_addr = 10'h020;
    tick;
    check_all_zero("rst_override");

    // Contention from reset release: D, I, D, I with acks 4 cycles apart
    reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick;
      check($sformatf("cont_d_ack_c%0d", c), 32'(d_ack), 32'((c % 8) == 3));
      check($sformatf("cont_i_ack_c%0d", c), 32'(i_ack), 32'((c % 8) == 7));
      check($sformatf("cont_mem_en_c%0d", c), 32'(mem_en), 32'((c % 4) == 1));
      if (c == 3) check("cont_d_rdata", d_rdata, 32'hA5A5_0020);
      if (c == 7) check("cont_i_rdata", i_rdata, 32'h0050_0093);
      if (c == 16) begin i_req = 0; d_req = 0; end
    end
    tick;
    check("cont_idle_mem_en", 32'(mem_en), 32'd0);

    // Single fetch
    i_req = 1; i_addr = 10'h004;
    tick;
    check("fetch_mem_en", 32'(mem_en), 32'd1);
    check("fetch_mem_addr", 32'(mem_addr), 32'h004);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    tick;
    check("fetch_wait_mem_en", 32'(mem_en), 32'd0);
    check("fetch_wait_mem_addr", 32'(mem_addr), 32'd0);
    check("fetch_wait_i_ack", 32'(i_ack), 32'd0);
    tick;
    check("fetch_i_ack", 32'(i_ack), 32'd1);
    check("fetch_d_ack", 32'(d_ack), 32'd0);
    check("fetch_i_rdata", i_rdata, 32'h0050_0093);
    i_req = 0;
    tick;
    check("fetch_ack_pulse", 32'(i_ack), 32'd0);

    // Write to top address; d_rdata must keep its previous value
    d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
    tick;
    check("wr_mem_en", 32'(mem_en), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'h3FF);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick;
    tick;
    check("wr_d_ack", 32'(d_ack), 32'd1);
    check("wr_i_ack", 32'(i_ack), 32'd0);
    check("wr_d_rdata_kept", d_rdata, 32'hA5A5_0020);
    d_req = 0; d_we = 0;
    tick;

    // Read back, holding d_req across the ack for a back-to-back access
    d_req = 1; d_addr = 10'h3FF; d_wdata = '0;
    tick;
    check("rd_mem_en", 32'(mem_en), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    tick;
    tick;
    check("rd_d_ack", 32'(d_ack), 32'd1);
    check("rd_d_rdata", d_rdata, 32'hDEAD_BEEF);
    tick;
    check("b2b_idle_mem_en", 32'(mem_en), 32'd0);
    check("b2b_idle_d_ack", 32'(d_ack), 32'd0);
    tick;
    check("b2b_mem_en", 32'(mem_en), 32'd1);
    d_req = 0;
    tick;
    tick;
    check("b2b_d_ack", 32'(d_ack), 32'd1);
    tick;

    // Reset during WAIT aborts the fetch
    i_req = 1; i_addr = 10'h010;
    tick;
    check("rstw_mem_addr", 32'(mem_addr), 32'h010);
    tick;
    reset = 1'b1;
    tick;
    check_all_zero("rstw");
    reset = 1'b0; i_addr = 10'h008;
    tick;
    check("rstw_new_mem_en", 32'(mem_en), 32'd1);
    check("rstw_new_mem_addr", 32'(mem_addr), 32'h008);
    tick;
    tick;
    check("rstw_new_i_ack", 32'(i_ack), 32'd1);
    check("rstw_new_i_rdata", i_rdata, 32'hA5A5_0008);
    i_req = 0;
    tick;

    // Address change after grant must not affect the access
    i_req = 1; i_addr = 10'h010;
    tick;
    i_addr = 10'h020;
    check("chg_mem_addr", 32'(mem_addr), 32'h010);
    tick;
    tick;
    check("chg_i_ack", 32'(i_ack), 32'd1);
    check("chg_i_rdata", i_rdata, 32'hA5A5_0010);
    i_req = 0;
    tick;
    check("chg_end_i_ack", 32'(i_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 10, word-address width of the shared memory (1024 words).
REQ-002 Parameter: DW, 32, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request, level, held until i_ack.
REQ-006 i_addr  input  AW  fetch word address, stable while i_req high.
REQ-007 i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-008 i_rdata  output  DW  registered fetch data, held until next i_ack.
REQ-009 d_req  input  1  data request, level, held until d_ack.
REQ-010 d_we  input  1  1 = write, 0 = read; stable while d_req high.
REQ-011 d_addr  input  AW  data word address.
REQ-012 d_wdata  input  DW  write data.
REQ-013 d_ack  output  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  output  DW  registered read data, held until next read d_ack.
REQ-015 mem_en  output  1  one-cycle memory access strobe.
REQ-016 mem_we  output  1  memory write enable, valid with mem_en.
REQ-017 mem_addr  output  AW  memory word address.
REQ-018 mem_wdata  output  DW  memory write data.
REQ-019 mem_rdata  input  DW  synchronous-read data, valid the cycle after mem_en.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-021 IDLE: if any req high, latch winner (port, we, addr, wdata) and go to ISSUE; else stay.
REQ-022 ISSUE: mem_en=1 and mem_we/addr/wdata driven from latched values for exactly this cycle; go to WAIT.
REQ-023 WAIT: capture mem_rdata into winner's rdata register (reads only); go to RESP.
REQ-024 RESP: winner's ack=1 for exactly this cycle; go to IDLE.
REQ-025 Latency: req seen in IDLE at cycle N -> mem_en at N+1 -> ack at N+3; max throughput one access per 4 cycles.
REQ-026 Arbitration: single requester wins; both high in IDLE -> round-robin on last_grant register (port not granted last wins).
REQ-027 last_grant updates only in IDLE on a grant.
REQ-028 Req high in the RESP cycle SHALL be ignored; arbitration is evaluated again only in the following IDLE cycle.
REQ-029 Write ack SHALL leave d_rdata unchanged; mem_we only ever asserted for data-port writes (fetch port is read-only).
REQ-030 Latched request fields SHALL not change between IDLE grant and RESP even if inputs change.
REQ-031 i_ack and d_ack SHALL never be high in the same cycle; mem_en high in at most 1 of any 4 consecutive cycles.
REQ-032 mem_addr/mem_wdata/mem_we SHALL be 0 when mem_en is 0.

Reset
REQ-033 reset high at any rising edge: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, last_grant=I (so D wins first tie).
REQ-034 Reset mid-transaction aborts it with no ack; a write already strobed in ISSUE is not undone; requester re-requests after reset.
REQ-035 Reset overrides all other inputs in the same cycle.

Verification
REQ-036 Single fetch: i_req=1, i_addr=0x004, mem holds 0x00500093 -> mem_en at N+1 addr 0x004, i_ack at N+3, i_rdata=0x00500093, d_ack stays 0.
REQ-037 Write then read: d_we=1, d_addr=0x3FF, d_wdata=0xDEADBEEF -> d_ack at N+3, d_rdata unchanged; then read 0x3FF -> d_rdata=0xDEADBEEF.
REQ-038 Contention: i_req and d_req held high from reset release -> grants D, I, D, I, acks every 4 cycles alternating, no starvation.
REQ-039 Back-to-back: d_req held high across its ack -> second mem_en no earlier than 2 cycles after first d_ack (RESP then IDLE).
REQ-040 Reset in WAIT: assert reset during a fetch's WAIT cycle -> no i_ack, all outputs 0 next cycle; new fetch after release completes normally in 3 cycles.
REQ-041 Input change after grant: change i_addr from 0x010 to 0x020 during ISSUE -> mem_addr=0x010 and i_rdata from 0x010.
